// File: rtl/spi_reg_sequencer.sv
// SPI-framed register file: a 16-bit header selects direction, start address and burst length,
// followed by 16-bit data words that are written to, or streamed back from, the register file.
module spi_reg_sequencer #(
   parameter  int NREGS = 8,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                  sclk,
   input  logic                  resetn,
   input  logic                  cs_n,
   input  logic                  sdi,
   output logic                  sdo,
   output logic [16*NREGS-1:0]   regs_q,
   output logic [2:0]            leds,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  frame_err
);

   typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

   localparam logic [AW:0] REM_ONE = (AW+1)'(1);

   state_t            state_q, state_d;
   logic [3:0]        bit_cnt_q, bit_cnt_d;
   logic [14:0]       rx_shift_q, rx_shift_d;
   logic [15:0]       tx_shift_q, tx_shift_d;
   logic              rw_q, rw_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [AW:0]       remaining_q, remaining_d;
   logic              sdo_q, sdo_d;
   logic              busy_q, busy_d;
   logic              frame_done_q, frame_done_d;
   logic              frame_err_q, frame_err_d;
   logic [15:0]       reg_file_q [NREGS];
   logic [15:0]       reg_file_d [NREGS];

   logic [15:0]       word_in;
   logic [AW-1:0]     addr_inc;

   // The word completing on this edge: 15 previously shifted bits plus the bit being sampled now.
   assign word_in  = {rx_shift_q, sdi};
   assign addr_inc = addr_q + AW'(1);

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      rx_shift_d   = rx_shift_q;
      tx_shift_d   = tx_shift_q;
      rw_d         = rw_q;
      addr_d       = addr_q;
      remaining_d  = remaining_q;
      frame_done_d = 1'b0;
      frame_err_d  = frame_err_q;
      reg_file_d   = reg_file_q;

      if (cs_n) begin
         state_d   = IDLE;
         bit_cnt_d = 4'd0;
         if (state_q == HDR || (state_q == DATA && remaining_q != '0))
            frame_err_d = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               state_d    = HDR;
               rx_shift_d = {rx_shift_q[13:0], sdi};
               bit_cnt_d  = 4'd1;
            end
            HDR: begin
               rx_shift_d = {rx_shift_q[13:0], sdi};
               bit_cnt_d  = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd15) begin
                  state_d     = DATA;
                  rw_d        = word_in[15];
                  addr_d      = word_in[AW-1:0];
                  remaining_d = {1'b0, word_in[2*AW-1:AW]} + REM_ONE;
                  tx_shift_d  = word_in[15] ? 16'h0000 : reg_file_q[word_in[AW-1:0]];
               end
            end
            DATA: begin
               rx_shift_d = {rx_shift_q[13:0], sdi};
               bit_cnt_d  = bit_cnt_q + 4'd1;
               tx_shift_d = {tx_shift_q[14:0], 1'b0};
               if (bit_cnt_q == 4'd15) begin
                  if (rw_q)
                     reg_file_d[addr_q] = word_in;
                  addr_d = addr_inc;
                  if (remaining_q != '0)
                     remaining_d = remaining_q - REM_ONE;
                  if (remaining_q <= REM_ONE) begin
                     state_d      = DONE;
                     frame_done_d = 1'b1;
                     frame_err_d  = 1'b0;
                     tx_shift_d   = 16'h0000;
                  end else if (!rw_q) begin
                     // Preload the next word so the read stream has no gap at the boundary.
                     tx_shift_d = reg_file_q[addr_inc];
                  end
               end
            end
            DONE: begin
               state_d = DONE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      sdo_d  = (state_d == DATA && !rw_d) ? tx_shift_d[15] : 1'b0;
      busy_d = (state_d == HDR) || (state_d == DATA);
   end

   always_ff @(posedge sclk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         bit_cnt_q    <= 4'd0;
         rx_shift_q   <= 15'd0;
         tx_shift_q   <= 16'h0000;
         rw_q         <= 1'b0;
         addr_q       <= '0;
         remaining_q  <= '0;
         sdo_q        <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
         for (int i = 0; i < NREGS; i++)
            reg_file_q[i] <= 16'h0000;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         rx_shift_q   <= rx_shift_d;
         tx_shift_q   <= tx_shift_d;
         rw_q         <= rw_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         sdo_q        <= sdo_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
         for (int i = 0; i < NREGS; i++)
            reg_file_q[i] <= reg_file_d[i];
      end
   end

   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_pack
         assign regs_q[16*gi +: 16] = reg_file_q[gi];
      end
      // A register that does not exist reads as zero, i.e. non-negative, so its LED is on.
      for (genvar gi = 0; gi < 3; gi++) begin : g_leds
         if (gi < NREGS) begin : g_real
            assign leds[gi] = ~reg_file_q[gi][15];
         end else begin : g_none
            assign leds[gi] = 1'b1;
         end
      end
   endgenerate

   assign sdo        = sdo_q;
   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Bench for spi_reg_sequencer: a directed frame table, reset-mid-frame sequence and random frames,
// all checked against a word-level model of the register file.
module tb_spi_reg_sequencer;

   localparam int NREGS = 8;
   localparam int AW    = $clog2(NREGS);

   logic                 sclk = 1'b0;
   logic                 resetn = 1'b0;
   logic                 cs_n = 1'b1;
   logic                 sdi = 1'b0;
   logic                 sdo;
   logic [16*NREGS-1:0]  regs_q;
   logic [2:0]           leds;
   logic                 busy;
   logic                 frame_done;
   logic                 frame_err;

   spi_reg_sequencer #(.NREGS(NREGS)) dut (
      .sclk       (sclk),
      .resetn     (resetn),
      .cs_n       (cs_n),
      .sdi        (sdi),
      .sdo        (sdo),
      .regs_q     (regs_q),
      .leds       (leds),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   always #5 sclk = ~sclk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Word-level model state and per-frame results
   logic [15:0] model [NREGS];
   logic        model_err;
   logic [15:0] fd [10];
   logic [15:0] rd_words [10];
   logic [15:0] exp_rd [10];
   int          exp_nrd;
   int          exp_done;
   int          done_pulses;

   typedef struct {
      logic [15:0] hdr;
      int          hbits;
      int          nbits;
      logic [15:0] d0, d1, d2;
      logic [15:0] r0, r1, r2;
      int          nrd;
      logic [2:0]  leds;
      logic        err;
      int          done;
      int          chk_idx;
      logic [15:0] chk_val;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   // Drives hbits header bits, nbits data bits, then one cs_n=1 edge; samples sdo before each data edge.
   task automatic do_frame(input logic [15:0] hdr, input int hbits, input int nbits);
      done_pulses = 0;
      for (int i = 0; i < hbits; i++) begin
         cs_n = 1'b0;
         sdi  = hdr[15-i];
         tick();
         if (frame_done) done_pulses++;
         if (i == 0) check("busy_in_hdr", 32'(busy), 32'd1);
      end
      for (int j = 0; j < nbits; j++) begin
         cs_n = 1'b0;
         sdi  = fd[j/16][15-(j%16)];
         rd_words[j/16][15-(j%16)] = sdo;
         tick();
         if (frame_done) done_pulses++;
      end
      cs_n = 1'b1;
      sdi  = 1'b0;
      tick();
      if (frame_done) done_pulses++;
      check("busy_after_frame", 32'(busy), 32'd0);
      check("sdo_idle", 32'(sdo), 32'd0);
   endtask

   // Reference: words fully delivered to a write frame land at consecutive addresses mod NREGS;
   // a read returns the pre-frame contents; a frame is clean only if every promised bit arrived.
   task automatic model_frame(input logic [15:0] hdr, input int hbits, input int nbits);
      int cnt, a, full, complete;
      cnt = ((int'(hdr) >> AW) % NREGS) + 1;
      a   = int'(hdr) % NREGS;
      complete = (hbits == 16) && (nbits >= 16*cnt);
      for (int k = 0; k < cnt; k++) exp_rd[k] = model[(a+k) % NREGS];
      full = (hbits == 16) ? ((nbits/16 < cnt) ? nbits/16 : cnt) : 0;
      exp_nrd = hdr[15] ? 0 : full;
      if (hdr[15])
         for (int k = 0; k < full; k++) model[(a+k) % NREGS] = fd[k];
      model_err = complete ? 1'b0 : 1'b1;
      exp_done  = complete ? 1 : 0;
   endtask

   task automatic compare_all();
      logic [2:0] exp_leds;
      for (int i = 0; i < NREGS; i++)
         check($sformatf("reg%0d", i), 32'(regs_q[16*i +: 16]), 32'(model[i]));
      for (int i = 0; i < 3; i++) exp_leds[i] = ~model[i][15];
      check("leds", 32'(leds), 32'(exp_leds));
      check("frame_err", 32'(frame_err), 32'(model_err));
      check("frame_done_pulses", 32'(done_pulses), 32'(exp_done));
      for (int k = 0; k < exp_nrd; k++)
         check($sformatf("read_word%0d", k), 32'(rd_words[k]), 32'(exp_rd[k]));
   endtask

   initial begin
      tbl[0] = '{16'h8010, 16, 48, 16'h1234, 16'hFFFF, 16'h8000, 16'h0, 16'h0, 16'h0, 0, 3'b001, 1'b0, 1, 2, 16'h8000};
      tbl[1] = '{16'h800E, 16, 32, 16'hAAAA, 16'h5555, 16'h0, 16'h0, 16'h0, 16'h0, 0, 3'b001, 1'b0, 1, 7, 16'h5555};
      tbl[2] = '{16'h0010, 16, 48, 16'h0, 16'h0, 16'h0, 16'h1234, 16'hFFFF, 16'h8000, 3, 3'b001, 1'b0, 1, 0, 16'h1234};
      tbl[3] = '{16'h8008, 16, 21, 16'h00FF, 16'h001F, 16'h0, 16'h0, 16'h0, 16'h0, 0, 3'b001, 1'b1, 0, 1, 16'hFFFF};
      tbl[4] = '{16'h8000, 16, 16, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 3'b001, 1'b0, 1, 0, 16'h7FFF};
      tbl[5] = '{16'h000F, 16, 32, 16'h0, 16'h0, 16'h0, 16'h5555, 16'h7FFF, 16'h0, 2, 3'b001, 1'b0, 1, 6, 16'hAAAA};
      tbl[6] = '{16'h8000, 8, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 3'b001, 1'b1, 0, 0, 16'h7FFF};
      tbl[7] = '{16'h8001, 16, 23, 16'h1111, 16'h2222, 16'h0, 16'h0, 16'h0, 16'h0, 0, 3'b011, 1'b0, 1, 2, 16'h8000};
      tbl[8] = '{16'h0001, 16, 25, 16'h0, 16'h0, 16'h0, 16'h1111, 16'h0, 16'h0, 1, 3'b011, 1'b0, 1, 1, 16'h1111};

      for (int i = 0; i < NREGS; i++) model[i] = 16'h0000;
      model_err = 1'b0;

      // Reset state
      resetn = 1'b0;
      cs_n   = 1'b1;
      tick();
      tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_sdo", 32'(sdo), 32'd0);
      check("rst_leds", 32'(leds), 32'd7);
      check("rst_regs_lo", regs_q[31:0], 32'd0);
      resetn = 1'b1;
      tick();

      // Directed frame table
      for (int v = 0; v < 9; v++) begin
         fd[0] = tbl[v].d0;
         fd[1] = tbl[v].d1;
         fd[2] = tbl[v].d2;
         for (int k = 3; k < 10; k++) fd[k] = 16'h0000;
         model_frame(tbl[v].hdr, tbl[v].hbits, tbl[v].nbits);
         do_frame(tbl[v].hdr, tbl[v].hbits, tbl[v].nbits);
         $display("[TB] vec %0d hdr=%h hbits=%0d nbits=%0d leds=%b err=%b done_pulses=%0d",
                  v, tbl[v].hdr, tbl[v].hbits, tbl[v].nbits, leds, frame_err, done_pulses);
         check($sformatf("vec%0d_leds", v), 32'(leds), 32'(tbl[v].leds));
         check($sformatf("vec%0d_err", v), 32'(frame_err), 32'(tbl[v].err));
         check($sformatf("vec%0d_done", v), 32'(done_pulses), 32'(tbl[v].done));
         check($sformatf("vec%0d_reg%0d", v, tbl[v].chk_idx),
               32'(regs_q[16*tbl[v].chk_idx +: 16]), 32'(tbl[v].chk_val));
         for (int k = 0; k < tbl[v].nrd; k++)
            check($sformatf("vec%0d_rd%0d", v, k), 32'(rd_words[k]),
                  32'((k == 0) ? tbl[v].r0 : (k == 1) ? tbl[v].r1 : tbl[v].r2));
         compare_all();
      end

      // Reset in the middle of a write burst, then a header right after reset with no cs_n gap
      fd[0] = 16'h1357;
      fd[1] = 16'h2468;
      for (int i = 0; i < 16; i++) begin
         cs_n = 1'b0;
         sdi  = 16'h8010 >> (15-i);
         tick();
      end
      for (int j = 0; j < 20; j++) begin
         cs_n = 1'b0;
         sdi  = fd[j/16][15-(j%16)];
         tick();
      end
      resetn = 1'b0;
      sdi    = 1'b1;
      tick();
      resetn = 1'b1;
      $display("[TB] reset mid-frame busy=%b err=%b leds=%b", busy, frame_err, leds);
      check("midrst_regs", 32'(|regs_q), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_err", 32'(frame_err), 32'd0);
      check("midrst_leds", 32'(leds), 32'd7);
      for (int i = 0; i < NREGS; i++) model[i] = 16'h0000;
      model_err = 1'b0;
      fd[0] = 16'hBEEF;
      model_frame(16'h8000, 16, 16);
      do_frame(16'h8000, 16, 16);
      $display("[TB] post-reset frame reg0=%h", regs_q[15:0]);
      check("postrst_reg0", 32'(regs_q[15:0]), 32'h0000BEEF);
      compare_all();

      // Random frames against the model
      for (int t = 0; t < 60; t++) begin
         logic [15:0] hdr;
         int cnt, mode, hbits, nbits;
         cnt = $urandom_range(1, NREGS);
         hdr = 16'($urandom);
         hdr[15] = 1'($urandom_range(0, 1));
         hdr[2*AW-1:AW] = AW'(cnt - 1);
         hdr[AW-1:0] = AW'($urandom_range(0, NREGS-1));
         for (int k = 0; k < 10; k++) fd[k] = 16'($urandom);
         mode  = $urandom_range(0, 5);
         hbits = 16;
         nbits = 16*cnt;
         if (mode == 0) begin
            hbits = $urandom_range(1, 15);
            nbits = 0;
         end else if (mode == 1) begin
            nbits = $urandom_range(0, 16*cnt-1);
         end else if (mode == 2) begin
            nbits = 16*cnt + $urandom_range(1, 20);
         end
         model_frame(hdr, hbits, nbits);
         do_frame(hdr, hbits, nbits);
         $display("[TB] rnd %0d hdr=%h hbits=%0d nbits=%0d err=%b done_pulses=%0d",
                  t, hdr, hbits, nbits, frame_err, done_pulses);
         compare_all();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
